// File: rtl/vid_frame_ctrl.sv
// Video timing controller: measures dv/hs/vs frame geometry, locks on stable frames and gates dv.
// Optional FRAME_CNT_EN adds a 16-bit counter of frames completed while locked.
module vid_frame_ctrl #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             dv_i,
  input  logic             hs_i,
  input  logic             vs_i,
  input  logic             err_clr_i,
  output logic             dv_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic             locked_o,
  output logic [CNT_W-1:0] width_o,
  output logic [CNT_W-1:0] height_o,
  output logic             frame_start_o,
`ifdef FRAME_CNT_EN
  output logic [15:0]      frame_cnt_o,
`endif
  output logic             err_o
);

  localparam int unsigned MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;
  localparam logic [CNT_W-1:0] CntNearMax = CntMax - 1'b1;

  typedef enum logic [2:0] {StIdle, StSeek, StMeasure, StVerify, StLocked} state_e;

  state_e           state_q, state_d;
  logic             dv_d, hs_d, vs_d, vs_rise_d;
  logic [CNT_W-1:0] pix_cnt_q, line_w_q, line_cnt_q;
  logic [CNT_W-1:0] pix_nxt, line_w_nxt, line_cnt_nxt;
  logic             line_bad_q, line_bad_nxt;
  logic [CNT_W-1:0] ref_w_q, ref_h_q, width_q, height_q;
  logic [MW-1:0]    match_q, match_inc;
  logic             err_q;
  logic             vs_rise, line_end, good, geom_eq;
  logic             load_ref, inc_match, load_geom, set_err;

  assign vs_rise   = vs_i & ~vs_d;
  assign line_end  = ~dv_i & dv_d;
  assign match_inc = match_q + MW'(1);

  // Next counter values; a line end coincident with vs_rise still belongs to the ending frame.
  always_comb begin
    pix_nxt      = pix_cnt_q;
    line_w_nxt   = line_w_q;
    line_cnt_nxt = line_cnt_q;
    line_bad_nxt = line_bad_q;
    if (line_end) begin
      pix_nxt = '0;
      if (line_cnt_q == '0) begin
        line_w_nxt = pix_cnt_q;
      end else if (pix_cnt_q != line_w_q) begin
        line_bad_nxt = 1'b1;
      end
      if (line_cnt_q != CntMax) line_cnt_nxt = line_cnt_q + 1'b1;
      if (line_cnt_q >= CntNearMax) line_bad_nxt = 1'b1;
    end else if (dv_i) begin
      if (pix_cnt_q != CntMax) pix_nxt = pix_cnt_q + 1'b1;
      if (pix_cnt_q >= CntNearMax) line_bad_nxt = 1'b1;
    end
  end

  assign good    = !line_bad_nxt && (line_cnt_nxt != '0);
  assign geom_eq = (line_w_nxt == ref_w_q) && (line_cnt_nxt == ref_h_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_d       <= 1'b0;
      hs_d       <= 1'b0;
      vs_d       <= 1'b0;
      vs_rise_d  <= 1'b0;
      pix_cnt_q  <= '0;
      line_w_q   <= '0;
      line_cnt_q <= '0;
      line_bad_q <= 1'b0;
    end else begin
      dv_d      <= dv_i;
      hs_d      <= hs_i;
      vs_d      <= vs_i;
      vs_rise_d <= vs_rise;
      if (vs_rise) begin
        pix_cnt_q  <= '0;
        line_w_q   <= '0;
        line_cnt_q <= '0;
        line_bad_q <= 1'b0;
      end else begin
        pix_cnt_q  <= pix_nxt;
        line_w_q   <= line_w_nxt;
        line_cnt_q <= line_cnt_nxt;
        line_bad_q <= line_bad_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_ref  = 1'b0;
    inc_match = 1'b0;
    load_geom = 1'b0;
    set_err   = 1'b0;
    unique case (state_q)
      StIdle:    if (en_i) state_d = StSeek;
      StSeek:    if (vs_rise) state_d = StMeasure;
      StMeasure: begin
        if (vs_rise && good) begin
          load_ref = 1'b1;
          state_d  = StVerify;
        end
      end
      StVerify: begin
        if (vs_rise) begin
          if (good && geom_eq) begin
            inc_match = 1'b1;
            if (match_inc == MW'(LOCK_FRAMES)) begin
              load_geom = 1'b1;
              state_d   = StLocked;
            end
          end else begin
            state_d = StMeasure;
          end
        end
      end
      StLocked: begin
        if (vs_rise && !(good && geom_eq)) begin
          set_err = 1'b1;
          state_d = StSeek;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en_i) begin
      state_d   = StIdle;
      load_ref  = 1'b0;
      inc_match = 1'b0;
      load_geom = 1'b0;
      set_err   = 1'b0;
    end
  end

  always_comb begin
    locked_o      = (state_q == StLocked);
    dv_o          = dv_d & locked_o;
    frame_start_o = vs_rise_d & locked_o;
    hs_o          = hs_d;
    vs_o          = vs_d;
    width_o       = width_q;
    height_o      = height_q;
    err_o         = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_w_q  <= '0;
      ref_h_q  <= '0;
      match_q  <= '0;
      width_q  <= '0;
      height_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (load_ref) begin
        ref_w_q <= line_w_nxt;
        ref_h_q <= line_cnt_nxt;
        match_q <= MW'(1);
      end else if (inc_match) begin
        match_q <= match_inc;
      end
      if (load_geom) begin
        width_q  <= ref_w_q;
        height_q <= ref_h_q;
      end
      if (set_err)        err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        frame_inc, lock_lost;

  assign frame_inc   = vs_rise && (state_q == StLocked) && (state_d == StLocked);
  assign lock_lost   = (state_q == StLocked) && (state_d != StLocked);
  assign frame_cnt_o = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || lock_lost) frame_cnt_q <= '0;
    else if (frame_inc)   frame_cnt_q <= frame_cnt_q + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vid_frame_ctrl.sv
// Bench for vid_frame_ctrl: per-cycle scoreboard of dv/hs/vs/locked/frame_start plus
// scenario checks of geometry, lock and sticky error.
module tb_vid_frame_ctrl;

  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst, en_i, dv_i, hs_i, vs_i, err_clr_i;
  logic dv_o, hs_o, vs_o, locked_o, frame_start_o, err_o;
  logic [CW-1:0] width_o, height_o;
`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_o;
`endif

  vid_frame_ctrl #(.CNT_W(CW), .LOCK_FRAMES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en_i),
    .dv_i         (dv_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
    .err_clr_i    (err_clr_i),
    .dv_o         (dv_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o),
    .locked_o     (locked_o),
    .width_o      (width_o),
    .height_o     (height_o),
    .frame_start_o(frame_start_o),
`ifdef FRAME_CNT_EN
    .frame_cnt_o  (frame_cnt_o),
`endif
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Expected per-cycle outputs {dv, hs, vs, locked, frame_start}, pushed at each active edge.
  logic [4:0] sbq[$];
  logic mon_en    = 1'b0;
  logic next_lock = 1'b0;
  logic exp_lock  = 1'b0;
  logic vs_prev   = 1'b0;
  logic mrise, exp_lock_n;

  assign mrise      = vs_i & ~vs_prev;
  assign exp_lock_n = !en_i ? 1'b0 : (mrise ? next_lock : exp_lock);

  always @(posedge clk) begin
    if (rst) begin
      vs_prev  <= 1'b0;
      exp_lock <= 1'b0;
    end else begin
      vs_prev  <= vs_i;
      exp_lock <= exp_lock_n;
      if (mon_en) sbq.push_back({dv_i & exp_lock_n, hs_i, vs_i, exp_lock_n, mrise & exp_lock_n});
    end
  end

  task automatic tick(input logic dv, input logic hs, input logic vs, input logic clr);
    logic [4:0] e;
    @(negedge clk);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      nchk += 5;
      if (dv_o !== e[4]) begin
        nerr++; $display("FAIL sb_dv t=%0t got %b want %b", $time, dv_o, e[4]);
      end
      if (hs_o !== e[3]) begin
        nerr++; $display("FAIL sb_hs t=%0t got %b want %b", $time, hs_o, e[3]);
      end
      if (vs_o !== e[2]) begin
        nerr++; $display("FAIL sb_vs t=%0t got %b want %b", $time, vs_o, e[2]);
      end
      if (locked_o !== e[1]) begin
        nerr++; $display("FAIL sb_locked t=%0t got %b want %b", $time, locked_o, e[1]);
      end
      if (frame_start_o !== e[0]) begin
        nerr++; $display("FAIL sb_frame_start t=%0t got %b want %b", $time, frame_start_o, e[0]);
      end
    end
    dv_i = dv; hs_i = hs; vs_i = vs; err_clr_i = clr;
  endtask

  // vs rise starts the frame; the frame it ends is judged at that rise.
  task automatic send_frame(input logic nl, input int w, input int h, input int bad,
                            input logic clr);
    next_lock = nl;
    tick(1'b0, 1'b0, 1'b1, clr);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int l = 0; l < h; l++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      for (int p = 0; p < ((l == bad) ? w - 1 : w); p++) tick(1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en_i = 1'b0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; err_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    nchk++;
    if ({dv_o, hs_o, vs_o, locked_o, frame_start_o, err_o, width_o, height_o} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs got %b/%b/%b/%b/%b/%b w=%0d h=%0d want all zero",
               dv_o, hs_o, vs_o, locked_o, frame_start_o, err_o, width_o, height_o);
    end
    rst = 1'b0; en_i = 1'b1; mon_en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_lock();
    send_frame(1'b0, 8, 4, -1, 1'b0);
    send_frame(1'b0, 8, 4, -1, 1'b0);
    send_frame(1'b1, 8, 4, -1, 1'b0);
    nchk += 3;
    if (width_o !== 12'd8) begin nerr++; $display("FAIL lock_width got %0d want 8", width_o); end
    if (height_o !== 12'd4) begin nerr++; $display("FAIL lock_height got %0d want 4", height_o); end
    if (err_o !== 1'b0) begin nerr++; $display("FAIL lock_err got %b want 0", err_o); end
  endtask

  task automatic test_bad_line();
    send_frame(1'b1, 8, 4, -1, 1'b0);
    send_frame(1'b1, 8, 4, 2, 1'b0);
    send_frame(1'b0, 8, 4, -1, 1'b0);
    nchk += 2;
    if (err_o !== 1'b1) begin nerr++; $display("FAIL bad_line_err got %b want 1", err_o); end
    if (locked_o !== 1'b0) begin nerr++; $display("FAIL bad_line_lock got %b want 0", locked_o); end
    send_frame(1'b0, 8, 4, -1, 1'b0);
    send_frame(1'b0, 8, 4, -1, 1'b0);
    send_frame(1'b1, 8, 4, -1, 1'b0);
    nchk += 2;
    if (locked_o !== 1'b1) begin nerr++; $display("FAIL relock got %b want 1", locked_o); end
    if (err_o !== 1'b1) begin nerr++; $display("FAIL err_sticky got %b want 1", err_o); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    nchk++;
    if (err_o !== 1'b0) begin nerr++; $display("FAIL err_clear got %b want 0", err_o); end
  endtask

  task automatic test_en_drop();
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);
    en_i = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    en_i = 1'b1;
    nchk += 2;
    if (dv_o !== 1'b0) begin nerr++; $display("FAIL en_drop_dv got %b want 0", dv_o); end
    if (locked_o !== 1'b0) begin nerr++; $display("FAIL en_drop_lock got %b want 0", locked_o); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_verify_mismatch();
    send_frame(1'b0, 8, 4, -1, 1'b0);
    send_frame(1'b0, 8, 5, -1, 1'b0);
    send_frame(1'b0, 8, 5, -1, 1'b0);
    nchk += 2;
    if (err_o !== 1'b0) begin nerr++; $display("FAIL verify_err got %b want 0", err_o); end
    if (height_o !== 12'd4) begin nerr++; $display("FAIL verify_hold got %0d want 4", height_o); end
    send_frame(1'b0, 8, 5, -1, 1'b0);
    send_frame(1'b1, 8, 5, -1, 1'b0);
    nchk += 2;
    if (width_o !== 12'd8) begin nerr++; $display("FAIL relock_width got %0d want 8", width_o); end
    if (height_o !== 12'd5) begin nerr++; $display("FAIL relock_height got %0d want 5", height_o); end
  endtask

  task automatic test_err_collision();
    send_frame(1'b1, 8, 5, 1, 1'b0);
    send_frame(1'b0, 8, 5, -1, 1'b1);
    nchk++;
    if (err_o !== 1'b1) begin nerr++; $display("FAIL collide_err got %b want 1", err_o); end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    nchk++;
    if (err_o !== 1'b0) begin nerr++; $display("FAIL collide_clear got %b want 0", err_o); end
  endtask

`ifdef FRAME_CNT_EN
  task automatic test_frame_cnt();
    send_frame(1'b0, 8, 4, -1, 1'b0);
    send_frame(1'b0, 8, 4, -1, 1'b0);
    send_frame(1'b1, 8, 4, -1, 1'b0);
    nchk++;
    if (frame_cnt_o !== 16'd0) begin nerr++; $display("FAIL fcnt_lock got %0d want 0", frame_cnt_o); end
    for (int i = 0; i < 5; i++) send_frame(1'b1, 8, 4, -1, 1'b0);
    nchk++;
    if (frame_cnt_o !== 16'd5) begin nerr++; $display("FAIL fcnt_five got %0d want 5", frame_cnt_o); end
    force dut.frame_cnt_q = 16'hFFFF;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    release dut.frame_cnt_q;
    send_frame(1'b1, 8, 4, -1, 1'b0);
    nchk++;
    if (frame_cnt_o !== 16'd0) begin nerr++; $display("FAIL fcnt_wrap got %0d want 0", frame_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_bad_line();
    test_en_drop();
    test_verify_mismatch();
    test_err_collision();
`ifdef FRAME_CNT_EN
    test_frame_cnt();
`endif
    repeat (3) tick(1'b0, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
